sync_fifo_v2: RTL

SYNC_FIFO_V2 -- requirements
Module: sync_fifo_v2

---
 rtl/sync_fifo_v2.sv | 128 ++++++++++++
 1 files changed

// File: rtl/sync_fifo_v2.sv
// Single-clock FIFO with registered status flags, sticky error flags and
// a selectable registered-read or first-word-fall-through read port.
module sync_fifo_v2 #(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 3,
   parameter int AF_THRESH = DEPTH - 1,
   parameter int AE_THRESH = 1,
   parameter int FWFT      = 0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       w_valid,
   input  logic [WIDTH-1:0]           data_in,
   input  logic                       r_ready,
   input  logic                       clr_err,
   output logic [WIDTH-1:0]           data_out,
   output logic                       r_valid,
   output logic                       fifo_full,
   output logic                       fifo_empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int LW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wptr;
   logic [PW-1:0]    r_rptr;
   logic [LW-1:0]    r_level;
   logic             r_full;
   logic             r_empty;
   logic             r_af;
   logic             r_ae;
   logic             r_ovf;
   logic             r_unf;

   logic             w_wr;
   logic             w_rd;
   logic             w_unf_set;
   logic [LW-1:0]    w_level_nxt;

   // Pointers wrap explicitly at DEPTH-1 so non-power-of-2 depths work.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // In FWFT mode r_valid mirrors ~r_empty, so one pop condition serves both modes.
   assign w_wr      = w_valid & ~r_full;
   assign w_rd      = r_ready & ~r_empty;
   assign w_unf_set = (FWFT == 0) && r_ready && r_empty;

   always_comb begin
      w_level_nxt = r_level;
      case ({w_wr, w_rd})
         2'b10:   w_level_nxt = r_level + LW'(1);
         2'b01:   w_level_nxt = r_level - LW'(1);
         default: w_level_nxt = r_level;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wptr] <= data_in;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
         r_af    <= 1'b0;
         r_ae    <= 1'b1;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else begin
         if (w_wr) r_wptr <= ptr_inc(r_wptr);
         if (w_rd) r_rptr <= ptr_inc(r_rptr);
         r_level <= w_level_nxt;
         r_full  <= (w_level_nxt == LW'(DEPTH));
         r_empty <= (w_level_nxt == '0);
         r_af    <= (int'(w_level_nxt) >= AF_THRESH);
         r_ae    <= (int'(w_level_nxt) <= AE_THRESH);
         // A new error event wins over a same-cycle clear.
         if (w_valid && r_full) r_ovf <= 1'b1;
         else if (clr_err)      r_ovf <= 1'b0;
         if (w_unf_set)         r_unf <= 1'b1;
         else if (clr_err)      r_unf <= 1'b0;
      end
   end

   generate
      if (FWFT == 0) begin : g_reg_read
         logic [WIDTH-1:0] r_dout;
         logic             r_rvalid;

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               r_dout   <= '0;
               r_rvalid <= 1'b0;
            end else begin
               if (w_rd) r_dout <= r_mem[r_rptr];
               r_rvalid <= w_rd;
            end
         end

         assign data_out = r_dout;
         assign r_valid  = r_rvalid;
      end else begin : g_fwft_read
         // Head word is exposed straight from storage; zero while empty.
         assign data_out = r_empty ? '0 : r_mem[r_rptr];
         assign r_valid  = ~r_empty;
      end
   endgenerate

   assign fifo_full    = r_full;
   assign fifo_empty   = r_empty;
   assign almost_full  = r_af;
   assign almost_empty = r_ae;
   assign level        = r_level;
   assign overflow     = r_ovf;
   assign underflow    = r_unf;

endmodule
